// File: rtl/sdram_port_arbiter_if.sv
// Bundled signals for the two client ports and the SDRAM controller command/response port.
// The arbiter uses the slave modport; the agent driving the ports and the controller uses master.
interface sdram_port_arbiter_if;
  logic [21:0] p0_addr;
  logic [1:0]  p0_be_n;
  logic [15:0] p0_wdata;
  logic        p0_rd_n;
  logic        p0_wr_n;
  logic        p0_waitrequest;
  logic [15:0] p0_rdata;
  logic        p0_valid;

  logic [21:0] p1_addr;
  logic [1:0]  p1_be_n;
  logic [15:0] p1_wdata;
  logic        p1_rd_n;
  logic        p1_wr_n;
  logic        p1_waitrequest;
  logic [15:0] p1_rdata;
  logic        p1_valid;

  logic [21:0] az_addr;
  logic [1:0]  az_be_n;
  logic [15:0] az_data;
  logic        az_rd_n;
  logic        az_wr_n;
  logic [15:0] za_data;
  logic        za_valid;
  logic        za_waitrequest;

  modport slave (
    input  p0_addr, p0_be_n, p0_wdata, p0_rd_n, p0_wr_n,
    output p0_waitrequest, p0_rdata, p0_valid,
    input  p1_addr, p1_be_n, p1_wdata, p1_rd_n, p1_wr_n,
    output p1_waitrequest, p1_rdata, p1_valid,
    output az_addr, az_be_n, az_data, az_rd_n, az_wr_n,
    input  za_data, za_valid, za_waitrequest
  );

  modport master (
    output p0_addr, p0_be_n, p0_wdata, p0_rd_n, p0_wr_n,
    input  p0_waitrequest, p0_rdata, p0_valid,
    output p1_addr, p1_be_n, p1_wdata, p1_rd_n, p1_wr_n,
    input  p1_waitrequest, p1_rdata, p1_valid,
    input  az_addr, az_be_n, az_data, az_rd_n, az_wr_n,
    output za_data, za_valid, za_waitrequest
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Two-port arbiter in front of an SDRAM controller: port 0 (CPU) and port 1 (DMA), one read outstanding.
// Optional macro SDRAM_ARB_ROUND_ROBIN_EN turns fixed priority (port 0 wins) into round-robin.
module sdram_port_arbiter #(
  parameter int unsigned RD_TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       reset_n,
  sdram_port_arbiter_if.slave        bus,
  output logic [1:0]                 grant,
  output logic                       rd_err
);
  localparam int unsigned CNT_W = 9;
  localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

  typedef enum logic [1:0] {IDLE, CMD, RDWAIT} state_t;

  state_t           state;
  logic [CNT_W-1:0] rd_cnt;

  logic req0;
  logic req1;
  logic pick1;
  logic sel;
  logic g_rd_n;
  logic g_wr_n;
  logic g_req;
  logic rsp_timeout;
  logic rsp_done;
  logic [15:0] rsp_data;

  assign req0 = ~bus.p0_rd_n | ~bus.p0_wr_n;
  assign req1 = ~bus.p1_rd_n | ~bus.p1_wr_n;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  // last1 remembers whether port 1 won the previous grant; a contest goes to the other port
  logic last1;
  assign pick1 = req1 & (~req0 | ~last1);
`else
  assign pick1 = req1 & ~req0;
`endif

  // Granted-port mux feeding the controller command port
  assign sel    = grant[1];
  assign g_rd_n = sel ? bus.p1_rd_n : bus.p0_rd_n;
  assign g_wr_n = sel ? bus.p1_wr_n : bus.p0_wr_n;
  assign g_req  = ~g_rd_n | ~g_wr_n;

  assign bus.az_addr = sel ? bus.p1_addr  : bus.p0_addr;
  assign bus.az_be_n = sel ? bus.p1_be_n  : bus.p0_be_n;
  assign bus.az_data = sel ? bus.p1_wdata : bus.p0_wdata;
  // Both strobes low is a write, so the read strobe is suppressed whenever write is asserted
  assign bus.az_wr_n = (state == CMD) ? g_wr_n : 1'b1;
  assign bus.az_rd_n = (state == CMD) ? (g_rd_n | ~g_wr_n) : 1'b1;

  assign bus.p0_waitrequest = (state == CMD && grant[0]) ? bus.za_waitrequest : 1'b1;
  assign bus.p1_waitrequest = (state == CMD && grant[1]) ? bus.za_waitrequest : 1'b1;

  assign rsp_timeout = (rd_cnt == CNT_W'(RD_TIMEOUT - 1));
  assign rsp_done    = (state == RDWAIT) && (bus.za_valid || rsp_timeout);
  assign rsp_data    = bus.za_valid ? bus.za_data : TIMEOUT_DATA;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      grant        <= 2'b00;
      rd_cnt       <= '0;
      rd_err       <= 1'b0;
      bus.p0_rdata <= '0;
      bus.p1_rdata <= '0;
      bus.p0_valid <= 1'b0;
      bus.p1_valid <= 1'b0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      last1        <= 1'b1;
`endif
    end else begin
      bus.p0_valid <= 1'b0;
      bus.p1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            grant <= pick1 ? 2'b10 : 2'b01;
            state <= CMD;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            last1 <= pick1;
`endif
          end
        end
        CMD: begin
          if (!g_req) begin
            state <= IDLE;
            grant <= 2'b00;
          end else if (!bus.za_waitrequest) begin
            if (!g_wr_n) begin
              state <= IDLE;
              grant <= 2'b00;
            end else begin
              state  <= RDWAIT;
              rd_cnt <= '0;
            end
          end
        end
        RDWAIT: begin
          if (rsp_done) begin
            if (sel) begin
              bus.p1_rdata <= rsp_data;
              bus.p1_valid <= 1'b1;
            end else begin
              bus.p0_rdata <= rsp_data;
              bus.p0_valid <= 1'b1;
            end
            if (!bus.za_valid) rd_err <= 1'b1;
            rd_cnt <= '0;
            state  <= IDLE;
            grant  <= 2'b00;
          end else begin
            rd_cnt <= rd_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_sdram_port_arbiter;
  localparam int RD_TO = 255;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] grant;
  logic       rd_err;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;
  int p0_pulses = 0;
  int p1_pulses = 0;
  int p0_wr0_cnt = 0;

  sdram_port_arbiter_if bus ();

  sdram_port_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .grant   (grant),
    .rd_err  (rd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_phase;   // 0 idle, 1 command offered, 2 waiting for read data
  bit          m_busy;
  bit          m_own;
  int          m_waited;
  logic [15:0] m_rdata [2];
  bit          m_valid [2];
  bit          m_err;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  bit          m_last1;
`endif

  function automatic logic m_rdn(input bit p);
    return p ? bus.p1_rd_n : bus.p0_rd_n;
  endfunction
  function automatic logic m_wrn(input bit p);
    return p ? bus.p1_wr_n : bus.p0_wr_n;
  endfunction
  function automatic bit m_req(input bit p);
    return (m_rdn(p) == 1'b0) || (m_wrn(p) == 1'b0);
  endfunction
  function automatic bit m_pick();
    if (m_req(1'b0) && m_req(1'b1)) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      return !m_last1;
`else
      return 1'b0;
`endif
    end
    return !m_req(1'b0);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase    <= 0;
      m_busy     <= 1'b0;
      m_own      <= 1'b0;
      m_waited   <= 0;
      m_rdata[0] <= 16'h0;
      m_rdata[1] <= 16'h0;
      m_valid[0] <= 1'b0;
      m_valid[1] <= 1'b0;
      m_err      <= 1'b0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      m_last1    <= 1'b1;
`endif
    end else begin
      m_valid[0] <= 1'b0;
      m_valid[1] <= 1'b0;
      if (m_phase == 0) begin
        if (m_req(1'b0) || m_req(1'b1)) begin
          m_busy  <= 1'b1;
          m_own   <= m_pick();
          m_phase <= 1;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
          m_last1 <= m_pick();
`endif
        end
      end else if (m_phase == 1) begin
        if (!m_req(m_own)) begin
          m_phase <= 0;
          m_busy  <= 1'b0;
        end else if (!bus.za_waitrequest) begin
          if (m_wrn(m_own) == 1'b0) begin
            m_phase <= 0;
            m_busy  <= 1'b0;
          end else begin
            m_phase  <= 2;
            m_waited <= 0;
          end
        end
      end else begin
        if (bus.za_valid) begin
          m_rdata[m_own] <= bus.za_data;
          m_valid[m_own] <= 1'b1;
          m_phase        <= 0;
          m_busy         <= 1'b0;
        end else if (m_waited + 1 == RD_TO) begin
          m_rdata[m_own] <= 16'hDEAD;
          m_valid[m_own] <= 1'b1;
          m_err          <= 1'b1;
          m_phase        <= 0;
          m_busy         <= 1'b0;
        end else begin
          m_waited <= m_waited + 1;
        end
      end
    end
  end

  function automatic logic [1:0] e_grant();
    if (!m_busy) return 2'b00;
    return m_own ? 2'b10 : 2'b01;
  endfunction
  function automatic logic e_azwr();
    return (m_phase == 1) ? m_wrn(m_own) : 1'b1;
  endfunction
  function automatic logic e_azrd();
    if (m_phase != 1) return 1'b1;
    if (m_wrn(m_own) == 1'b0) return 1'b1;
    return m_rdn(m_own);
  endfunction
  function automatic logic e_wait(input bit p);
    return (m_phase == 1 && m_own == p) ? bus.za_waitrequest : 1'b1;
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("grant", 32'(grant), 32'(e_grant()));
      chk("az_wr_n", 32'(bus.az_wr_n), 32'(e_azwr()));
      chk("az_rd_n", 32'(bus.az_rd_n), 32'(e_azrd()));
      chk("p0_waitrequest", 32'(bus.p0_waitrequest), 32'(e_wait(1'b0)));
      chk("p1_waitrequest", 32'(bus.p1_waitrequest), 32'(e_wait(1'b1)));
      chk("p0_valid", 32'(bus.p0_valid), 32'(m_valid[0]));
      chk("p1_valid", 32'(bus.p1_valid), 32'(m_valid[1]));
      chk("p0_rdata", 32'(bus.p0_rdata), 32'(m_rdata[0]));
      chk("p1_rdata", 32'(bus.p1_rdata), 32'(m_rdata[1]));
      chk("rd_err", 32'(rd_err), 32'(m_err));
      if (m_phase == 1) begin
        chk("az_addr", 32'(bus.az_addr), 32'(m_own ? bus.p1_addr : bus.p0_addr));
        chk("az_be_n", 32'(bus.az_be_n), 32'(m_own ? bus.p1_be_n : bus.p0_be_n));
        chk("az_data", 32'(bus.az_data), 32'(m_own ? bus.p1_wdata : bus.p0_wdata));
      end
    end
  end

  always @(negedge clk) begin
    if (bus.p0_valid === 1'b1) p0_pulses++;
    if (bus.p1_valid === 1'b1) p1_pulses++;
    if (cmp_en && bus.p0_waitrequest === 1'b0) p0_wr0_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic release_all();
    bus.p0_rd_n = 1'b1; bus.p0_wr_n = 1'b1;
    bus.p1_rd_n = 1'b1; bus.p1_wr_n = 1'b1;
  endtask

  // Assert one command on a port, hold it until accepted, then release it
  task automatic issue(input bit p, input bit wr, input logic [21:0] a,
                       input logic [15:0] d, input logic [1:0] be);
    bit done;
    done = 1'b0;
    tick();
    if (!p) begin
      bus.p0_addr = a; bus.p0_wdata = d; bus.p0_be_n = be;
      if (wr) bus.p0_wr_n = 1'b0; else bus.p0_rd_n = 1'b0;
    end else begin
      bus.p1_addr = a; bus.p1_wdata = d; bus.p1_be_n = be;
      if (wr) bus.p1_wr_n = 1'b0; else bus.p1_rd_n = 1'b0;
    end
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if ((p ? bus.p1_waitrequest : bus.p0_waitrequest) == 1'b0) done = 1'b1;
    end
    tick();
    release_all();
    chk("issue_accepted", 32'(done), 32'd1);
  endtask

  task automatic respond(input int dly, input logic [15:0] d);
    repeat (dly) tick();
    bus.za_valid = 1'b1;
    bus.za_data  = d;
    tick();
    bus.za_valid = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  logic [1:0] gseq [4];
  logic [1:0] gexp;
  logic [21:0] hold_addr;
  int n;
  int base;
  bit seen;
  bit got;

  initial begin
    reset_n = 1'b0;
    release_all();
    bus.p0_addr = '0; bus.p0_be_n = 2'b11; bus.p0_wdata = '0;
    bus.p1_addr = '0; bus.p1_be_n = 2'b11; bus.p1_wdata = '0;
    bus.za_data = '0; bus.za_valid = 1'b0; bus.za_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_az_rd_n", 32'(bus.az_rd_n), 32'd1);
    chk("rst_az_wr_n", 32'(bus.az_wr_n), 32'd1);
    chk("rst_p0_wait", 32'(bus.p0_waitrequest), 32'd1);
    chk("rst_p1_wait", 32'(bus.p1_waitrequest), 32'd1);
    chk("rst_p1_rdata", 32'(bus.p1_rdata), 32'd0);
    chk("rst_rd_err", 32'(rd_err), 32'd0);
    tick();
    reset_n = 1'b1;

    // Both ports hammer reads: grant sequence
    tick();
    bus.p0_addr = 22'h000010; bus.p1_addr = 22'h000020;
    bus.p0_rd_n = 1'b0; bus.p1_rd_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      gseq[k] = 2'b00;
      for (int i = 0; i < 32 && !got; i++) begin
        @(negedge clk);
        if (bus.az_rd_n == 1'b0) begin got = 1'b1; gseq[k] = grant; end
      end
      chk("contest_accept", 32'(got), 32'd1);
      tick();
      respond(2, 16'h1000 + 16'(k));
    end
    release_all();
    for (int k = 0; k < 4; k++) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      gexp = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
      gexp = 2'b01;
`endif
      chk("contest_grant", 32'(gseq[k]), 32'(gexp));
    end

    // Port 0 write, zero-wait controller
    tick();
    bus.p0_addr = 22'h000100; bus.p0_wdata = 16'h1234; bus.p0_be_n = 2'b00; bus.p0_wr_n = 1'b0;
    tick();
    @(negedge clk);
    chk("wr_grant", 32'(grant), 32'd1);
    chk("wr_az_wr_n", 32'(bus.az_wr_n), 32'd0);
    chk("wr_az_rd_n", 32'(bus.az_rd_n), 32'd1);
    chk("wr_az_addr", 32'(bus.az_addr), 32'h000100);
    chk("wr_az_data", 32'(bus.az_data), 32'h1234);
    chk("wr_az_be_n", 32'(bus.az_be_n), 32'd0);
    chk("wr_p0_wait", 32'(bus.p0_waitrequest), 32'd0);
    tick();
    release_all();
    @(negedge clk);
    chk("wr_done_grant", 32'(grant), 32'd0);
    chk("wr_done_az_wr_n", 32'(bus.az_wr_n), 32'd1);

    // Port 1 read of top address, data returned five cycles later
    base = p1_pulses;
    p0_wr0_cnt = 0;
    issue(1'b1, 1'b0, 22'h3FFFFF, 16'h0, 2'b00);
    respond(4, 16'hBEEF);
    @(negedge clk);
    chk("rd_p1_valid", 32'(bus.p1_valid), 32'd1);
    chk("rd_p1_rdata", 32'(bus.p1_rdata), 32'hBEEF);
    repeat (3) tick();
    chk("rd_p1_pulses", 32'(p1_pulses - base), 32'd1);
    chk("rd_p0_wait_low", 32'(p0_wr0_cnt), 32'd0);

    // Controller stalls ten cycles during a port 0 write
    bus.za_waitrequest = 1'b1;
    bus.p0_addr = 22'h2AAAAA; bus.p0_wdata = 16'h55AA; bus.p0_be_n = 2'b01; bus.p0_wr_n = 1'b0;
    tick();
    hold_addr = bus.az_addr;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_p0_wait", 32'(bus.p0_waitrequest), 32'd1);
      chk("stall_az_wr_n", 32'(bus.az_wr_n), 32'd0);
      chk("stall_az_addr", 32'(bus.az_addr), 32'h2AAAAA);
    end
    tick();
    bus.za_waitrequest = 1'b0;
    @(negedge clk);
    chk("stall_release_wait", 32'(bus.p0_waitrequest), 32'd0);
    tick();
    release_all();
    @(negedge clk);
    chk("stall_done_grant", 32'(grant), 32'd0);

    // Both strobes low is a write: no read wait follows
    tick();
    bus.p1_addr = 22'h00ABCD; bus.p1_wdata = 16'hF00D; bus.p1_rd_n = 1'b0; bus.p1_wr_n = 1'b0;
    tick();
    @(negedge clk);
    chk("both_az_wr_n", 32'(bus.az_wr_n), 32'd0);
    chk("both_az_rd_n", 32'(bus.az_rd_n), 32'd1);
    tick();
    release_all();
    @(negedge clk);
    chk("both_done_grant", 32'(grant), 32'd0);

    // Port abandons its command before acceptance
    bus.za_waitrequest = 1'b1;
    bus.p0_rd_n = 1'b0;
    tick();
    @(negedge clk);
    chk("abandon_grant", 32'(grant), 32'd1);
    tick();
    release_all();
    tick();
    @(negedge clk);
    chk("abandon_idle_grant", 32'(grant), 32'd0);
    bus.za_waitrequest = 1'b0;

    // Read timeout, then normal service resumes
    issue(1'b1, 1'b0, 22'h123456, 16'h0, 2'b00);
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (bus.p1_valid == 1'b1) seen = 1'b1;
    end
    chk("to_seen", 32'(seen), 32'd1);
    chk("to_latency", 32'(n), 32'd256);
    chk("to_rd_err", 32'(rd_err), 32'd1);
    chk("to_p1_rdata", 32'(bus.p1_rdata), 32'hDEAD);
    issue(1'b0, 1'b1, 22'h000200, 16'hCAFE, 2'b00);
    issue(1'b0, 1'b0, 22'h000200, 16'h0, 2'b00);
    respond(1, 16'h5A5A);
    @(negedge clk);
    chk("post_to_p0_valid", 32'(bus.p0_valid), 32'd1);
    chk("post_to_p0_rdata", 32'(bus.p0_rdata), 32'h5A5A);
    chk("post_to_rd_err", 32'(rd_err), 32'd1);

    // Reset during a read wait drops the read
    issue(1'b0, 1'b0, 22'h000055, 16'h0, 2'b00);
    tick();
    base = p0_pulses;
    reset_n = 1'b0;
    #1;
    chk("arst_grant", 32'(grant), 32'd0);
    chk("arst_rd_err", 32'(rd_err), 32'd0);
    chk("arst_p0_rdata", 32'(bus.p0_rdata), 32'd0);
    chk("arst_p1_rdata", 32'(bus.p1_rdata), 32'd0);
    tick();
    reset_n = 1'b1;
    bus.za_valid = 1'b1;
    bus.za_data  = 16'hC0DE;
    tick();
    bus.za_valid = 1'b0;
    repeat (4) tick();
    chk("arst_no_pulse", 32'(p0_pulses - base), 32'd0);
    chk("arst_after_p0_rdata", 32'(bus.p0_rdata), 32'd0);
    chk("arst_after_grant", 32'(grant), 32'd0);
    chk("arst_after_az_rd_n", 32'(bus.az_rd_n), 32'd1);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL have parameter RD_TIMEOUT, default 255, the maximum number of cycles to wait for za_valid after a read is accepted.
REQ-002 SHALL have clk, input, 1, the single clock for all logic.
REQ-003 SHALL have reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have pN_addr (N=0,1), input, 22, word address; port 0 is the CPU northbridge and port 1 is the bus-master/DMA.
REQ-005 SHALL have pN_be_n, input, 2, active-low byte enables {H,L}.
REQ-006 SHALL have pN_wdata, input, 16, write data.
REQ-007 SHALL have pN_rd_n and pN_wr_n, input, 1 each, active-low command strobes.
REQ-008 SHALL have pN_waitrequest, output, 1, which stalls the port's command.
REQ-009 SHALL have pN_rdata, output, 16, read data.
REQ-010 SHALL have pN_valid, output, 1, a one-cycle read-data strobe.
REQ-011 SHALL have az_addr (output, 22), az_be_n (output, 2), az_data (output, 16), az_rd_n (output, 1) and az_wr_n (output, 1), forming the SDRAM controller command port.
REQ-012 SHALL have za_data (input, 16), za_valid (input, 1) and za_waitrequest (input, 1), the SDRAM controller response.
REQ-013 SHALL have grant, output, 2, one-hot owner of the SDRAM port; 00 means idle.
REQ-014 SHALL have rd_err, output, 1, a sticky read-timeout flag.

Function
REQ-015 SHALL treat a port as requesting when pN_rd_n=0 or pN_wr_n=0; both strobes low SHALL be handled as a write.
REQ-016 SHALL implement the states IDLE, CMD and RDWAIT.
REQ-017 IDLE: when any port is requesting, SHALL register grant on the next clk edge and move to CMD; with no request it SHALL stay in IDLE with grant=00.
REQ-018 CMD: SHALL drive az_* combinationally from the granted port; all non-granted ports SHALL see waitrequest=1.
REQ-019 CMD: the granted port's waitrequest SHALL equal za_waitrequest.
REQ-020 CMD: a command is accepted on the first cycle with a strobe low and za_waitrequest=0.
REQ-021 CMD: an accepted write SHALL move to IDLE and clear grant.
REQ-022 CMD: an accepted read SHALL move to RDWAIT.
REQ-023 CMD: if the granted port releases both strobes before acceptance, SHALL return to IDLE with no command issued.
REQ-024 RDWAIT: az_rd_n and az_wr_n SHALL be 1, and both ports SHALL see waitrequest=1.
REQ-025 RDWAIT: on za_valid=1, SHALL copy za_data to the granted port's pN_rdata, pulse its pN_valid on the next cycle, then go to IDLE.
REQ-026 pN_rdata SHALL hold its value until the next read completes on that port.
REQ-027 At most one read SHALL be outstanding; a new grant SHALL never issue before the read data returns.
REQ-028 A 9-bit counter SHALL count RDWAIT cycles; reaching RD_TIMEOUT SHALL set rd_err=1, return 16'hDEAD with a pN_valid pulse, and go to IDLE.
REQ-029 za_valid outside RDWAIT SHALL be ignored.
REQ-030 Minimum write latency: request at cycle 0, grant at cycle 1, accept at cycle 1 when za_waitrequest=0.
REQ-031 Arbitration (fixed priority): simultaneous requests in IDLE SHALL grant port 0.

Reset
REQ-032 reset_n=0 SHALL force, asynchronously, state=IDLE, grant=00, az_rd_n=1, az_wr_n=1, pN_waitrequest=1, pN_valid=0, pN_rdata=0, rd_err=0 and timeout counter=0.
REQ-033 A reset asserted mid-command or mid-read SHALL drop the transaction and SHALL NOT emit a pN_valid pulse for it after release.
REQ-034 rd_err SHALL be cleared only by reset.

Configuration
REQ-035 With macro SDRAM_ARB_ROUND_ROBIN_EN defined, SHALL grant simultaneous requests to the port not most recently granted; the last-granted bit resets to port 1, so the first contest goes to port 0.
REQ-036 Without SDRAM_ARB_ROUND_ROBIN_EN, arbitration SHALL be fixed priority with port 0 winning (REQ-031), and the last-granted register SHALL be absent.

Verification
REQ-037 Scenario: port 0 write to addr 0x000100, data 0x1234, be_n=00, za_waitrequest=0 -> az_wr_n low for 1 cycle with matching az_*, grant=01, then grant=00.
REQ-038 Scenario: port 1 read of 0x3FFFFF, za_valid 5 cycles after acceptance with za_data=0xBEEF -> p1_rdata=0xBEEF, one p1_valid pulse, p0_waitrequest=1 throughout.
REQ-039 Scenario: both ports continuously requesting reads -> without the macro, every grant goes to port 0; with the macro, grants alternate 01,10,01,10.
REQ-040 Scenario: za_waitrequest held at 1 for 10 cycles during CMD -> command stable, granted pN_waitrequest=1 for those 10 cycles, accepted on cycle 11.
REQ-041 Scenario: read accepted with no za_valid -> after 255 cycles rd_err=1, pN_rdata=0xDEAD with a valid pulse, and the next request is serviced normally.
REQ-042 Scenario: reset_n pulsed low during RDWAIT, then za_valid arrives -> no pN_valid pulse, all outputs at reset values.
